mpu_alu: RTL and testbench

- Registered integer ALU for the MPU core.
- Extracts three sized operand lanes (a, b, c) from three 64-bit source words, executes one of 16 opcodes, and registers a zero-extended 64-bit result plus an 8-bit flag vector.
- Sits between the MPU register file/decoder and the writeback/branch logic; flag bit T drives conditional test instructions (mask, masked compare, less-than).

---
 rtl/mpu_alu_pkg.sv | 57 +++++
 rtl/mpu_alu_lane_sel.sv | 21 ++
 rtl/mpu_alu.sv | 128 ++++++++++++
 tb/tb_mpu_alu.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mpu_alu_pkg.sv
// Shared constants and width helpers for the MPU integer ALU.
// Optional shifter is controlled by the MPU_ALU_SHIFT_EN define (see mpu_alu.sv).
package mpu_alu_pkg;

  localparam logic [3:0] MPU_ALU_MOV  = 4'h0;
  localparam logic [3:0] MPU_ALU_MASK = 4'h1;
  localparam logic [3:0] MPU_ALU_CMPM = 4'h2;
  localparam logic [3:0] MPU_ALU_LTU  = 4'h3;
  localparam logic [3:0] MPU_ALU_ADD  = 4'h4;
  localparam logic [3:0] MPU_ALU_SUB  = 4'h5;
  localparam logic [3:0] MPU_ALU_AND  = 4'h6;
  localparam logic [3:0] MPU_ALU_OR   = 4'h7;
  localparam logic [3:0] MPU_ALU_XOR  = 4'h8;
  localparam logic [3:0] MPU_ALU_NOT  = 4'h9;
  localparam logic [3:0] MPU_ALU_SHL  = 4'hA;
  localparam logic [3:0] MPU_ALU_SHR  = 4'hB;
  localparam logic [3:0] MPU_ALU_LTS  = 4'hC;
  localparam logic [3:0] MPU_ALU_EQ   = 4'hD;

  localparam logic [1:0] MPU_SZ_8  = 2'd0;
  localparam logic [1:0] MPU_SZ_16 = 2'd1;
  localparam logic [1:0] MPU_SZ_32 = 2'd2;
  localparam logic [1:0] MPU_SZ_64 = 2'd3;

  localparam int MPU_FLAG_T = 0;
  localparam int MPU_FLAG_Z = 1;
  localparam int MPU_FLAG_N = 2;
  localparam int MPU_FLAG_C = 3;

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      MPU_SZ_8:  size_mask = 64'h0000_0000_0000_00FF;
      MPU_SZ_16: size_mask = 64'h0000_0000_0000_FFFF;
      MPU_SZ_32: size_mask = 64'h0000_0000_FFFF_FFFF;
      default:   size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [5:0] size_msb(input logic [1:0] size);
    case (size)
      MPU_SZ_8:  size_msb = 6'd7;
      MPU_SZ_16: size_msb = 6'd15;
      MPU_SZ_32: size_msb = 6'd31;
      default:   size_msb = 6'd63;
    endcase
  endfunction

  function automatic logic [6:0] size_bits(input logic [1:0] size);
    case (size)
      MPU_SZ_8:  size_bits = 7'd8;
      MPU_SZ_16: size_bits = 7'd16;
      MPU_SZ_32: size_bits = 7'd32;
      default:   size_bits = 7'd64;
    endcase
  endfunction

endpackage

// File: rtl/mpu_alu_lane_sel.sv
// Picks one sized lane out of a 64-bit source word and zero-extends it.
module mpu_alu_lane_sel
  import mpu_alu_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  idx,
  input  logic [1:0]  size,
  output logic [63:0] lane
);

  always_comb begin
    lane = '0;
    case (size)
      MPU_SZ_8:  lane = {56'b0, word[{idx, 3'b000} +: 8]};
      MPU_SZ_16: lane = {48'b0, word[{idx[1:0], 4'b0000} +: 16]};
      MPU_SZ_32: lane = {32'b0, (idx[0] ? word[63:32] : word[31:0])};
      default:   lane = word;
    endcase
  end

endmodule

// File: rtl/mpu_alu.sv
// Registered 16-opcode integer ALU with sized operand lanes and T/Z/N/C flags.
// Define MPU_ALU_SHIFT_EN to build the SHL/SHR shifter; otherwise those opcodes act as reserved.
module mpu_alu
  import mpu_alu_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  size,
  input  logic [3:0]  op,
  input  logic [63:0] o0,
  input  logic [63:0] o1,
  input  logic [63:0] o2,
  input  logic [2:0]  s0,
  input  logic [2:0]  s1,
  input  logic [2:0]  s2,
  output logic [63:0] res,
  output logic [7:0]  flags
);

  logic [63:0] a, b, c;
  logic [63:0] mask;
  logic [5:0]  msb;
  logic [64:0] sum;
  logic [63:0] diff;
  logic        carry_add;
  logic        ltu, lts;
  logic [63:0] nxt_res;
  logic        nxt_t, nxt_c, valid;
  logic [7:0]  nxt_flags;

  mpu_alu_lane_sel u_lane_a (.word(o0), .idx(s0), .size(size), .lane(a));
  mpu_alu_lane_sel u_lane_b (.word(o1), .idx(s1), .size(size), .lane(b));
  mpu_alu_lane_sel u_lane_c (.word(o2), .idx(s2), .size(size), .lane(c));

  // Lanes are zero-extended, so the carry out of bit W-1 lands in sum bit W.
  always_comb begin
    mask = size_mask(size);
    msb  = size_msb(size);
    sum  = {1'b0, a} + {1'b0, b};
    diff = (a - b) & mask;
    ltu  = (a < b);
    lts  = (a[msb] != b[msb]) ? a[msb] : ltu;
    case (size)
      MPU_SZ_8:  carry_add = sum[8];
      MPU_SZ_16: carry_add = sum[16];
      MPU_SZ_32: carry_add = sum[32];
      default:   carry_add = sum[64];
    endcase
  end

`ifdef MPU_ALU_SHIFT_EN
  logic        shift_oor;
  logic [63:0] shl_res, shr_res;

  // Any shift count of W or more empties the lane entirely.
  always_comb begin
    shift_oor = (b >= {57'b0, size_bits(size)});
    shl_res   = shift_oor ? 64'b0 : ((a << b[5:0]) & mask);
    shr_res   = shift_oor ? 64'b0 : (a >> b[5:0]);
  end
`endif

  always_comb begin
    nxt_res = '0;
    nxt_t   = 1'b0;
    nxt_c   = 1'b0;
    valid   = 1'b1;
    case (op)
      MPU_ALU_MOV: nxt_res = a;
      MPU_ALU_MASK: begin
        nxt_t   = ((a & b) == 64'b0) && ((~a & c) == 64'b0) && ((b | c) == mask);
        nxt_res = a & c;
      end
      MPU_ALU_CMPM: begin
        nxt_t   = ((a & c) == (b & c));
        nxt_res = (a ^ b) & c;
      end
      MPU_ALU_LTU: begin
        nxt_t   = ltu;
        nxt_res = diff;
      end
      MPU_ALU_ADD: begin
        nxt_res = sum[63:0] & mask;
        nxt_c   = carry_add;
      end
      MPU_ALU_SUB: begin
        nxt_res = diff;
        nxt_c   = ltu;
      end
      MPU_ALU_AND: nxt_res = a & b;
      MPU_ALU_OR:  nxt_res = a | b;
      MPU_ALU_XOR: nxt_res = a ^ b;
      MPU_ALU_NOT: nxt_res = ~a & mask;
`ifdef MPU_ALU_SHIFT_EN
      MPU_ALU_SHL: nxt_res = shl_res;
      MPU_ALU_SHR: nxt_res = shr_res;
`endif
      MPU_ALU_LTS: begin
        nxt_t   = lts;
        nxt_res = diff;
      end
      MPU_ALU_EQ: begin
        nxt_t   = (a == b);
        nxt_res = a ^ b;
      end
      default: valid = 1'b0;
    endcase

    nxt_flags = '0;
    if (valid) begin
      nxt_flags[MPU_FLAG_T] = nxt_t;
      nxt_flags[MPU_FLAG_Z] = (nxt_res == 64'b0);
      nxt_flags[MPU_FLAG_N] = nxt_res[msb];
      nxt_flags[MPU_FLAG_C] = nxt_c;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      res   <= '0;
      flags <= '0;
    end else begin
      res   <= nxt_res;
      flags <= nxt_flags;
    end
  end

endmodule

// File: tb/tb_mpu_alu.sv
// Directed self-checking bench for mpu_alu; hand-computed vectors, one cycle latency.
module tb_mpu_alu;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [1:0]  size;
  logic [3:0]  op;
  logic [63:0] o0, o1, o2;
  logic [2:0]  s0, s1, s2;
  logic [63:0] res;
  logic [7:0]  flags;

  int total;
  int bad;

  mpu_alu dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .size      (size),
    .op        (op),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .res       (res),
    .flags     (flags)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic applyStimulus(input logic [3:0] op_v, input logic [1:0] size_v,
                               input logic [63:0] o0_v, input logic [63:0] o1_v,
                               input logic [63:0] o2_v, input logic [2:0] s0_v,
                               input logic [2:0] s1_v, input logic [2:0] s2_v);
    op   = op_v;
    size = size_v;
    o0   = o0_v;
    o1   = o1_v;
    o2   = o2_v;
    s0   = s0_v;
    s1   = s1_v;
    s2   = s2_v;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] exp_res,
                             input logic [7:0] exp_flags);
    total++;
    assert (res === exp_res) else begin
      bad++;
      $error("[TB] FAIL %s res: got=%h want=%h", tag, res, exp_res);
    end
    total++;
    assert (flags === exp_flags) else begin
      bad++;
      $error("[TB] FAIL %s flags: got=%h want=%h", tag, flags, exp_flags);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    sys_rst_n = 1'b0;
    op = 4'h4; size = 2'd3;
    o0 = 64'h1; o1 = 64'h1; o2 = 64'h0;
    s0 = 3'd0; s1 = 3'd0; s2 = 3'd0;
    #12;
    checkOutput("reset_hold", 64'h0, 8'h00);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput("reset_release_add", 64'h2, 8'h00);

    applyStimulus(4'h1, 2'd0, 64'h55, 64'hAA00, 64'h55_0000, 3'd0, 3'd1, 3'd2);
    checkOutput("mask_true", 64'h55, 8'h01);
    applyStimulus(4'h1, 2'd0, 64'h55, 64'hAA00, 64'h15_0000, 3'd0, 3'd1, 3'd2);
    checkOutput("mask_m1_short", 64'h15, 8'h00);
    applyStimulus(4'h1, 2'd0, 64'h55, 64'h2A00, 64'h55_0000, 3'd0, 3'd1, 3'd2);
    checkOutput("mask_m0_short", 64'h55, 8'h00);

    applyStimulus(4'h2, 2'd0, 64'h55, 64'h55, 64'hFF, 3'd0, 3'd0, 3'd0);
    checkOutput("cmpm_equal", 64'h0, 8'h03);
    applyStimulus(4'h2, 2'd0, 64'h55, 64'h54, 64'hFF, 3'd0, 3'd0, 3'd0);
    checkOutput("cmpm_diff", 64'h01, 8'h00);
    applyStimulus(4'h2, 2'd0, 64'h55, 64'h54, 64'hFE, 3'd0, 3'd0, 3'd0);
    checkOutput("cmpm_masked", 64'h0, 8'h03);

    applyStimulus(4'h3, 2'd0, 64'h54, 64'h55, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("ltu_true", 64'hFF, 8'h05);
    applyStimulus(4'h3, 2'd0, 64'h55, 64'h55, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("ltu_equal", 64'h0, 8'h02);

    applyStimulus(4'h4, 2'd1, 64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000, 64'h0,
                  3'd3, 3'd3, 3'd0);
    checkOutput("add16_carry", 64'h0, 8'h0A);
    applyStimulus(4'h5, 2'd2, 64'h0, 64'h1, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("sub32_borrow", 64'hFFFF_FFFF, 8'h0C);

    applyStimulus(4'h0, 2'd2, 64'hDEAD_BEEF_0000_0000, 64'h0, 64'h0, 3'd1, 3'd0, 3'd0);
    checkOutput("mov32_hi", 64'hDEAD_BEEF, 8'h04);
    applyStimulus(4'h8, 2'd1, 64'h1234_0000, 64'h00FF_0000, 64'h0, 3'd1, 3'd1, 3'd0);
    checkOutput("xor16_lane1", 64'h12CB, 8'h00);
    applyStimulus(4'h6, 2'd0, 64'hF0_0000_0000_0000, 64'h3C, 64'h0, 3'd6, 3'd0, 3'd0);
    checkOutput("and8_lane6", 64'h30, 8'h00);
    applyStimulus(4'h7, 2'd0, 64'h81, 64'h02, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("or8", 64'h83, 8'h04);
    applyStimulus(4'h9, 2'd0, 64'h0F, 64'h0, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("not8", 64'hF0, 8'h04);
    applyStimulus(4'hC, 2'd0, 64'h80, 64'h01, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("lts8_neg", 64'h7F, 8'h01);
    applyStimulus(4'h3, 2'd0, 64'h80, 64'h01, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("ltu8_same_operands", 64'h7F, 8'h00);
    applyStimulus(4'hD, 2'd0, 64'h33, 64'h33, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("eq8_true", 64'h0, 8'h03);
    applyStimulus(4'hD, 2'd0, 64'h33, 64'h31, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("eq8_false", 64'h02, 8'h00);

`ifdef MPU_ALU_SHIFT_EN
    applyStimulus(4'hA, 2'd3, 64'h1, 64'd63, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("shl64_63", 64'h8000_0000_0000_0000, 8'h04);
    applyStimulus(4'hA, 2'd3, 64'h1, 64'd64, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("shl64_64", 64'h0, 8'h02);
    applyStimulus(4'hA, 2'd0, 64'h01, 64'h09, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("shl8_oor", 64'h0, 8'h02);
    applyStimulus(4'hB, 2'd1, 64'h8000, 64'd15, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("shr16_15", 64'h1, 8'h00);
`else
    applyStimulus(4'hA, 2'd3, 64'h1, 64'd63, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("shl_disabled", 64'h0, 8'h00);
    applyStimulus(4'hB, 2'd1, 64'h8000, 64'd15, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("shr_disabled", 64'h0, 8'h00);
`endif

    applyStimulus(4'hE, 2'd0, 64'h0, 64'h0, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("reserved_e", 64'h0, 8'h00);
    applyStimulus(4'hF, 2'd3, 64'h5, 64'h5, 64'h5, 3'd0, 3'd0, 3'd0);
    checkOutput("reserved_f", 64'h0, 8'h00);

    // A reset landing between edges must wipe the in-flight result at once.
    applyStimulus(4'h4, 2'd3, 64'h5, 64'h6, 64'h0, 3'd0, 3'd0, 3'd0);
    checkOutput("add64_pre_reset", 64'hB, 8'h00);
    o0 = 64'h7;
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 64'h0, 8'h00);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput("post_reset_add", 64'hD, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
